pipe_reg: RTL and testbench

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_reg.sv | 99 +++++++++
 tb/tb_pipe_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg.sv
// Elastic pipeline register: DEPTH stages with valid/ready handshaking, bubble collapse and flush.
// Optional occupancy counter port 'occ' is built when PIPE_REG_OCC_EN is defined.
module pipe_reg #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush
`ifdef PIPE_REG_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_load;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];
  logic             full_tail;

  // A stage can load unless it and every stage after it are full while the sink stalls.
  always_comb begin
    stage_load = '0;
    full_tail  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      full_tail = 1'b1;
      for (int j = i; j < DEPTH; j++) begin
        full_tail = full_tail & stage_valid[j];
      end
      stage_load[i] = out_ready | ~full_tail;
    end
  end

  always_comb begin
    src_valid    = '0;
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_valid[i] = stage_valid[i-1];
      src_data[i]  = stage_data[i-1];
    end
  end

  assign in_ready  = rst & ~flush & stage_load[0];
  assign out_valid = stage_valid[DEPTH-1] & ~flush;
  assign out_data  = stage_data[DEPTH-1];

  // Data only moves when a valid word arrives, so empty advances leave stale data untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stage_data[i] <= '0;
      end
    end else if (flush) begin
      stage_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (stage_load[i]) begin
          stage_valid[i] <= src_valid[i];
          if (src_valid[i]) begin
            stage_data[i] <= src_data[i];
          end
        end
      end
    end
  end

`ifdef PIPE_REG_OCC_EN
  localparam int OCC_W = $clog2(DEPTH+1);

  logic up_xfer;
  logic down_xfer;

  assign up_xfer   = in_valid & in_ready;
  assign down_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else if (up_xfer && !down_xfer) begin
      occ <= occ + OCC_W'(1);
    end else if (down_xfer && !up_xfer) begin
      occ <= occ - OCC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Directed bench for pipe_reg (WIDTH=9, DEPTH=3): streaming, backpressure, bubble collapse, flush, async reset.
// The occ checks are built only when PIPE_REG_OCC_EN is defined for the whole compile.
module tb_pipe_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       flush;
`ifdef PIPE_REG_OCC_EN
  logic [1:0] occ;
`endif

  int checks   = 0;
  int failures = 0;

  pipe_reg #(.WIDTH(9), .DEPTH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush)
`ifdef PIPE_REG_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [8:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOcc(input string tag, input logic [1:0] expected);
`ifdef PIPE_REG_OCC_EN
    checkOutput(tag, 64'(occ), 64'(expected));
`else
    if (expected === 2'bxx) $display("[TB] unreachable %s", tag);
`endif
  endtask

  task automatic checkOut(input string tag, input logic v, input logic [8:0] d);
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'(v));
    if (v) checkOutput({tag, "_data"}, 64'(out_data), 64'(d));
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 9'h000, 1'b0, 1'b0);
    #2 rst = 1'b0;

    // reset state
    settle();
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOcc("rst_occ", 2'd0);
    tick();
    rst = 1'b1;
    settle();
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

    // streaming with out_ready=1
    tick(); applyStimulus(1'b1, 9'h001, 1'b1, 1'b0);
    settle(); checkOutput("st_in_ready", 64'(in_ready), 64'd1); checkOut("st0", 1'b0, 9'h0);
    tick(); applyStimulus(1'b1, 9'h002, 1'b1, 1'b0);
    settle(); checkOut("st1", 1'b0, 9'h0); checkOcc("st1_occ", 2'd1);
    tick(); applyStimulus(1'b1, 9'h003, 1'b1, 1'b0);
    settle(); checkOut("st2", 1'b0, 9'h0); checkOcc("st2_occ", 2'd2);
    tick(); applyStimulus(1'b1, 9'h004, 1'b1, 1'b0);
    settle(); checkOut("st3", 1'b1, 9'h001); checkOcc("st3_occ", 2'd3);
    checkOutput("st3_in_ready", 64'(in_ready), 64'd1);
    tick(); applyStimulus(1'b1, 9'h005, 1'b1, 1'b0);
    settle(); checkOut("st4", 1'b1, 9'h002); checkOcc("st4_occ", 2'd3);
    tick(); applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    settle(); checkOut("st5", 1'b1, 9'h003); checkOcc("st5_occ", 2'd3);
    tick(); settle(); checkOut("st6", 1'b1, 9'h004); checkOcc("st6_occ", 2'd2);
    tick(); settle(); checkOut("st7", 1'b1, 9'h005); checkOcc("st7_occ", 2'd1);
    tick(); settle(); checkOut("st8", 1'b0, 9'h0); checkOcc("st8_occ", 2'd0);

    // backpressure with out_ready=0
    tick(); applyStimulus(1'b1, 9'h1A0, 1'b0, 1'b0);
    settle(); checkOutput("bp0_in_ready", 64'(in_ready), 64'd1);
    tick(); applyStimulus(1'b1, 9'h1A1, 1'b0, 1'b0);
    settle(); checkOutput("bp1_in_ready", 64'(in_ready), 64'd1);
    tick(); applyStimulus(1'b1, 9'h1A2, 1'b0, 1'b0);
    settle(); checkOutput("bp2_in_ready", 64'(in_ready), 64'd1);
    tick(); applyStimulus(1'b1, 9'h1A3, 1'b0, 1'b0);
    settle(); checkOutput("bp3_in_ready", 64'(in_ready), 64'd0);
    checkOut("bp3", 1'b1, 9'h1A0); checkOcc("bp3_occ", 2'd3);
    tick(); settle();
    checkOutput("bp4_in_ready", 64'(in_ready), 64'd0);
    checkOut("bp4_hold", 1'b1, 9'h1A0); checkOcc("bp4_occ", 2'd3);
    tick(); applyStimulus(1'b1, 9'h1A3, 1'b1, 1'b0);
    settle(); checkOutput("bp5_in_ready", 64'(in_ready), 64'd1); checkOut("bp5", 1'b1, 9'h1A0);
    tick(); applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    settle(); checkOut("bp6", 1'b1, 9'h1A1); checkOcc("bp6_occ", 2'd3);
    tick(); settle(); checkOut("bp7", 1'b1, 9'h1A2); checkOcc("bp7_occ", 2'd2);
    tick(); settle(); checkOut("bp8", 1'b1, 9'h1A3); checkOcc("bp8_occ", 2'd1);
    tick(); settle(); checkOut("bp9", 1'b0, 9'h0); checkOcc("bp9_occ", 2'd0);

    // bubble collapse
    tick(); applyStimulus(1'b1, 9'h055, 1'b0, 1'b0);
    tick(); applyStimulus(1'b0, 9'h000, 1'b0, 1'b0);
    tick(); settle(); checkOut("bc_mid", 1'b0, 9'h0);
    tick(); applyStimulus(1'b1, 9'h0AA, 1'b0, 1'b0);
    settle(); checkOut("bc_first", 1'b1, 9'h055);
    tick(); applyStimulus(1'b0, 9'h000, 1'b0, 1'b0);
    settle(); checkOcc("bc_occ_a", 2'd2);
    tick(); settle();
    checkOut("bc_hold", 1'b1, 9'h055); checkOcc("bc_occ_b", 2'd2);
    checkOutput("bc_in_ready", 64'(in_ready), 64'd1);
    tick(); applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    settle(); checkOut("bc_drain0", 1'b1, 9'h055);
    tick(); settle(); checkOut("bc_drain1", 1'b1, 9'h0AA);
    tick(); settle(); checkOut("bc_empty", 1'b0, 9'h0);

    // flush while full
    tick(); applyStimulus(1'b1, 9'h010, 1'b0, 1'b0);
    tick(); applyStimulus(1'b1, 9'h011, 1'b0, 1'b0);
    tick(); applyStimulus(1'b1, 9'h012, 1'b0, 1'b0);
    tick(); applyStimulus(1'b1, 9'h013, 1'b1, 1'b1);
    settle();
    checkOutput("fl_in_ready", 64'(in_ready), 64'd0);
    checkOutput("fl_out_valid", 64'(out_valid), 64'd0);
    checkOcc("fl_occ_before", 2'd3);
    tick(); applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    settle();
    checkOutput("fl_after_out_valid", 64'(out_valid), 64'd0);
    checkOutput("fl_after_in_ready", 64'(in_ready), 64'd1);
    checkOutput("fl_data_hold", 64'(out_data), 64'h010);
    checkOcc("fl_after_occ", 2'd0);

    // async reset with pipe full
    tick(); applyStimulus(1'b1, 9'h155, 1'b0, 1'b0);
    tick(); applyStimulus(1'b1, 9'h0F0, 1'b0, 1'b0);
    tick(); applyStimulus(1'b1, 9'h1FF, 1'b0, 1'b0);
    tick(); applyStimulus(1'b0, 9'h000, 1'b0, 1'b0);
    #1 checkOut("ar_full", 1'b1, 9'h155);
    #1 rst = 1'b0;
    #1;
    checkOutput("ar_out_valid", 64'(out_valid), 64'd0);
    checkOutput("ar_out_data", 64'(out_data), 64'd0);
    checkOutput("ar_in_ready", 64'(in_ready), 64'd0);
    checkOcc("ar_occ", 2'd0);
    tick(); rst = 1'b1;
    settle();
    checkOutput("ar_rel_in_ready", 64'(in_ready), 64'd1);
    checkOut("ar_rel", 1'b0, 9'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
